canvas_reader: RTL
==================

# canvas_reader

Reads the 140x196 drawing canvas back out of the pixel frame buffer and reduces it to a 28x28 grid of ink counts, the input vector for the neural network. It is the read side of the canvas. The write side stamps 11x15 brush blocks and clears the region starting at (89,33). `canvas_reader` scans that region cell by cell, issuing one frame-buffer read per cycle. It emits one result per 5x7-pixel cell.

## Interface

Parameters:
- `X_BASE`, default 89: canvas left edge, in pixels.
- `Y_BASE`, default 33: canvas top edge, in pixels.
- `CELL_W`, default 5: cell width, in pixels.
- `CELL_H`, default 7: cell height, in pixels.
- `GRID`, default 28: cells per row and cells per column.
- `THRESH`, default 1: minimum ink count for `cell_bit`=1.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin a scan; sampled only in IDLE.
- `abort`  in  1  synchronous scan cancel.
- `rd_en`  out  1  frame-buffer read strobe.
- `rd_x`  out  8  read x address.
- `rd_y`  out  8  read y address.
- `rd_data`  in  1  ink bit; valid exactly 1 cycle after `rd_en`.
- `cell_valid`  out  1  one-cycle strobe: cell result valid.
- `cell_index`  out  10  cell number, row*GRID+col, range 0..783.
- `cell_value`  out  6  ink pixel count in the cell, range 0..35.
- `cell_bit`  out  1  `cell_value` >= `THRESH`.
- `busy`  out  1  scan in progress.
- `done`  out  1  one-cycle strobe: scan complete.

## Operation

- FSM states: IDLE, SCAN, DRAIN, DONE.
- IDLE -> SCAN on `start`=1 with `abort`=0.
- SCAN -> DRAIN after the last read.
- DRAIN -> DONE after 2 cycles.
- DONE -> IDLE after 1 cycle.
- `abort`=1 in any state -> IDLE at the next edge. Accumulator is cleared; no further `cell_valid`; no `done`.
- Counters, nested innermost first: `dx` 0..CELL_W-1, `dy` 0..CELL_H-1, `col` 0..GRID-1, `row` 0..GRID-1. Each wraps to 0 and carries into the next.
- Read address: `rd_x` = X_BASE + col*CELL_W + dx; `rd_y` = Y_BASE + row*CELL_H + dy.
- Address arithmetic is 8-bit. Parameters must satisfy X_BASE+GRID*CELL_W-1 <= 255, and likewise for y. With defaults, the maximum address is 228 on both axes.
- Accumulator, 6-bit: adds `rd_data` on each cycle that follows a read.
- On the data cycle of a cell's last pixel:
  - `cell_value` <= acc + `rd_data`;
  - acc <= 0;
  - `cell_index` <= that cell's index;
  - `cell_valid` <= 1.
- `rd_data` is ignored in every cycle that does not follow an `rd_en` cycle.
- `start` is ignored while `busy`=1.
- Simultaneous `start` and `abort` in IDLE: `abort` wins; the FSM stays in IDLE.

## Timing

Reset values, forced while `resetn`=0 and held in IDLE:
- `rd_x`=X_BASE, `rd_y`=Y_BASE;
- `rd_en`, `cell_valid`, `done`, `busy`, `cell_bit` = 0;
- `cell_value`, `cell_index`, acc, all counters = 0.

Assertion of `resetn`=0 mid-scan returns the FSM to IDLE immediately. No `done` is issued.

Cycle numbering counts from the edge E0 at which `start` is accepted.
- Cycles 1..27440: `rd_en`=1 continuously, with no bubbles; GRID²·CELL_W·CELL_H reads in total.
- `busy` is 1 from cycle 1 through the `done` cycle, inclusive.
- A pixel read in cycle k has its `rd_data` in cycle k+1.
- If k is a cell's last pixel, that cell's `cell_valid`, `cell_value` and `cell_bit` are presented in cycle k+2.
- `cell_valid` therefore fires every 35 cycles: first in cycle 37, last (index 783) in cycle 27442.
- `done`=1 in cycle 27443. IDLE from cycle 27444; a new `start` is accepted at the edge ending cycle 27444.
- After an `abort` sampled at the end of cycle n, `rd_en`=0 and `cell_valid`=0 from cycle n+1.

## Test plan

- Blank canvas, `rd_data`=0: expect 784 `cell_valid` pulses.
  - Indices 0..783 in order; every `cell_value`=0 and `cell_bit`=0.
  - First pulse in cycle 37, `done` in cycle 27443.
- Full ink, `rd_data`=1: every `cell_value`=35 and every `cell_bit`=1. Per cell, `rd_data` stays low for cycles after non-read cycles.
- Single ink pixel at (106,109): only `cell_index`=283 reports `cell_value`=1 and `cell_bit`=1; all other cells report 0.
- Address sequence:
  - reads 1..6 go to (89,33), (90,33), (91,33), (92,33), (93,33), (89,34);
  - read 36 goes to (94,33);
  - the final read goes to (228,228);
  - `rd_en` goes low in the cycle after the final read.
- `abort` asserted in cycle 1000:
  - `rd_en`=0 from cycle 1001; no further `cell_valid`; no `done`;
  - a following `start` gives a full scan beginning at index 0 with acc=0.
- `resetn` pulsed low at cycle 5000: all outputs go to reset values immediately. A `start` pulse at cycle 3000 during the scan is ignored: the address sequence and cell results are unaffected.

Source files
------------

// File: rtl/canvas_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : canvas_reader                                              |
// | Description : Scans the drawing canvas out of the pixel frame buffer,    |
// |               one read per cycle, and reduces it to a GRID x GRID array  |
// |               of per-cell ink counts plus a thresholded bit per cell.    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module canvas_reader #(
  parameter int X_BASE = 89,
  parameter int Y_BASE = 33,
  parameter int CELL_W = 5,
  parameter int CELL_H = 7,
  parameter int GRID   = 28,
  parameter int THRESH = 1
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic       abort,
  output logic       rd_en,
  output logic [7:0] rd_x,
  output logic [7:0] rd_y,
  input  logic       rd_data,
  output logic       cell_valid,
  output logic [9:0] cell_index,
  output logic [5:0] cell_value,
  output logic       cell_bit,
  output logic       busy,
  output logic       done
);

  localparam int c_dx_w = (CELL_W > 1) ? $clog2(CELL_W) : 1;
  localparam int c_dy_w = (CELL_H > 1) ? $clog2(CELL_H) : 1;
  localparam int c_g_w  = (GRID   > 1) ? $clog2(GRID)   : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [c_dx_w-1:0] dx_q, dx_d;
  logic [c_dy_w-1:0] dy_q, dy_d;
  logic [c_g_w-1:0]  col_q, col_d;
  logic [c_g_w-1:0]  row_q, row_d;
  logic [9:0]        idx_q, idx_d;          // index of the cell being read
  logic              drain_q, drain_d;      // second DRAIN cycle marker
  logic              pend_q, pend_d;        // previous cycle issued a read
  logic              pend_last_q, pend_last_d;
  logic [9:0]        pend_idx_q, pend_idx_d;
  logic [5:0]        acc_q, acc_d;
  logic              cell_valid_q, cell_valid_d;
  logic [9:0]        cell_index_q, cell_index_d;
  logic [5:0]        cell_value_q, cell_value_d;
  logic              cell_bit_q, cell_bit_d;

  logic              w_dx_last, w_dy_last, w_col_last, w_row_last;
  logic              w_cell_last, w_scan_last;
  logic [5:0]        w_sum;

  assign w_dx_last   = (dx_q  == c_dx_w'(CELL_W - 1));
  assign w_dy_last   = (dy_q  == c_dy_w'(CELL_H - 1));
  assign w_col_last  = (col_q == c_g_w'(GRID - 1));
  assign w_row_last  = (row_q == c_g_w'(GRID - 1));
  assign w_cell_last = w_dx_last && w_dy_last;
  assign w_scan_last = w_cell_last && w_col_last && w_row_last;

  // Next-state, scan counters and accumulator/result datapath
  always_comb begin
    state_d      = state_q;
    dx_d         = dx_q;
    dy_d         = dy_q;
    col_d        = col_q;
    row_d        = row_q;
    idx_d        = idx_q;
    drain_d      = drain_q;
    pend_d       = 1'b0;
    pend_last_d  = 1'b0;
    pend_idx_d   = pend_idx_q;
    acc_d        = acc_q;
    cell_valid_d = 1'b0;
    cell_index_d = cell_index_q;
    cell_value_d = cell_value_q;
    cell_bit_d   = cell_bit_q;
    w_sum        = acc_q + 6'(rd_data);

    // rd_data is meaningful only in the cycle right after a read
    if (pend_q && !abort) begin
      if (pend_last_q) begin
        cell_value_d = w_sum;
        cell_bit_d   = (int'(w_sum) >= THRESH);
        cell_index_d = pend_idx_q;
        cell_valid_d = 1'b1;
        acc_d        = 6'd0;
      end else begin
        acc_d        = w_sum;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_SCAN;
      end
      S_SCAN: begin
        pend_d      = 1'b1;
        pend_last_d = w_cell_last;
        pend_idx_d  = idx_q;
        dx_d        = w_dx_last ? '0 : dx_q + c_dx_w'(1);
        if (w_dx_last) dy_d = w_dy_last ? '0 : dy_q + c_dy_w'(1);
        if (w_cell_last) begin
          col_d = w_col_last ? '0 : col_q + c_g_w'(1);
          idx_d = idx_q + 10'd1;
          if (w_col_last) row_d = w_row_last ? '0 : row_q + c_g_w'(1);
        end
        if (w_scan_last) begin
          state_d = S_DRAIN;
          idx_d   = 10'd0;
          drain_d = 1'b0;
        end
      end
      S_DRAIN: begin
        if (drain_q) state_d = S_DONE;
        drain_d = 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
        drain_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    // Cancel wins over everything, including a start in IDLE
    if (abort) begin
      state_d     = S_IDLE;
      dx_d        = '0;
      dy_d        = '0;
      col_d       = '0;
      row_d       = '0;
      idx_d       = 10'd0;
      drain_d     = 1'b0;
      pend_d      = 1'b0;
      pend_last_d = 1'b0;
      acc_d       = 6'd0;
    end
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      dx_q         <= '0;
      dy_q         <= '0;
      col_q        <= '0;
      row_q        <= '0;
      idx_q        <= 10'd0;
      drain_q      <= 1'b0;
      pend_q       <= 1'b0;
      pend_last_q  <= 1'b0;
      pend_idx_q   <= 10'd0;
      acc_q        <= 6'd0;
      cell_valid_q <= 1'b0;
      cell_index_q <= 10'd0;
      cell_value_q <= 6'd0;
      cell_bit_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      col_q        <= col_d;
      row_q        <= row_d;
      idx_q        <= idx_d;
      drain_q      <= drain_d;
      pend_q       <= pend_d;
      pend_last_q  <= pend_last_d;
      pend_idx_q   <= pend_idx_d;
      acc_q        <= acc_d;
      cell_valid_q <= cell_valid_d;
      cell_index_q <= cell_index_d;
      cell_value_q <= cell_value_d;
      cell_bit_q   <= cell_bit_d;
    end
  end

  assign rd_en      = (state_q == S_SCAN);
  assign rd_x       = 8'(X_BASE + int'(col_q) * CELL_W + int'(dx_q));
  assign rd_y       = 8'(Y_BASE + int'(row_q) * CELL_H + int'(dy_q));
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign cell_valid = cell_valid_q;
  assign cell_index = cell_index_q;
  assign cell_value = cell_value_q;
  assign cell_bit   = cell_bit_q;

endmodule
`default_nettype wire
